// File: rtl/pwm_carrier_gen.sv
// pwm_carrier_gen: single PWM carrier counter with shadowed period and mode.
// UP, DOWN and UPDOWN counting, phase load and resync, and zero/peak strobes.
// Period and mode only change at a count boundary, so a running carrier
// never goes past its active peak.
module pwm_carrier_gen #(
    parameter int CNT_WIDTH   = 16,
    parameter int RESET_PHASE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] init_carr,
    input  logic [1:0]           count_mode,
    input  logic                 pwm_onoff,
    input  logic                 carr_onoff,
    input  logic                 sync_in,
    output logic [CNT_WIDTH-1:0] carrier,
    output logic                 dir,
    output logic                 zero_evt,
    output logic                 peak_evt,
    output logic                 running
);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    typedef enum logic [1:0] {
        M_UP     = 2'b00,
        M_DOWN   = 2'b01,
        M_UPDOWN = 2'b10,
        M_RSVD   = 2'b11
    } mode_e;

    // Active (shadowed) copies of period/mode and last-cycle phase input
    cnt_t  period_act;
    mode_e mode_act;
    cnt_t  init_q;

    mode_e mode_in;
    logic  run_en;
    logic  resync;
    logic  load_idle;
    logic  bnd;
    logic  step_dn;

    cnt_t  car_nx;
    cnt_t  per_nx;
    mode_e mode_nx;
    logic  dir_nx;
    logic  run_nx;
    logic  zero_nx;
    logic  peak_nx;

    assign mode_in = mode_e'(count_mode);
    assign run_en  = pwm_onoff & carr_onoff & (period_act != '0);
    assign resync  = sync_in | (init_carr != init_q);

    // The first enabled cycle also takes the load path: the carrier holds the
    // value loaded while idle, giving one cycle before the first step.
    assign load_idle = !run_en || !running;

    function automatic cnt_t clamp(input cnt_t v, input cnt_t lim);
        return (v > lim) ? lim : v;
    endfunction

    // Next-state selection: idle load > resync > normal count with boundary update
    always_comb begin
        car_nx  = carrier;
        dir_nx  = dir;
        per_nx  = period_act;
        mode_nx = mode_act;
        bnd     = 1'b0;
        step_dn = 1'b0;

        if (load_idle) begin
            per_nx  = period;
            mode_nx = mode_in;
            car_nx  = clamp(init_carr, period);
            dir_nx  = (mode_in == M_DOWN);
        end else if (resync) begin
            // Phase jump only; the shadowed period/mode stay where they are
            car_nx = clamp(init_carr, period_act);
            dir_nx = (mode_act == M_DOWN);
        end else begin
            case (mode_act)
                M_DOWN:   bnd = (carrier == '0);
                M_UPDOWN: bnd = (carrier == '0);
                default:  bnd = (carrier >= period_act);
            endcase

            if (bnd) begin
                per_nx  = period;
                mode_nx = mode_in;
            end

            case (mode_act)
                M_DOWN: begin
                    // Reload uses the freshly shadowed period
                    car_nx = bnd ? period : (carrier - 1'b1);
                    dir_nx = bnd ? (mode_in == M_DOWN) : 1'b1;
                end
                M_UPDOWN: begin
                    // Turnaround at 0 always steps up; no dwell at either end
                    step_dn = !bnd && (dir || (carrier >= period_act));
                    car_nx  = step_dn ? (carrier - 1'b1) : (carrier + 1'b1);
                    if (bnd && (mode_in != M_UPDOWN))
                        dir_nx = (mode_in == M_DOWN);
                    else if (car_nx >= per_nx)
                        dir_nx = 1'b1;
                    else if (car_nx == '0)
                        dir_nx = 1'b0;
                    else
                        dir_nx = step_dn;
                end
                default: begin
                    car_nx = bnd ? '0 : (carrier + 1'b1);
                    dir_nx = bnd ? (mode_in == M_DOWN) : 1'b0;
                end
            endcase
        end

        // A zero period about to become active never counts as running, so
        // zero/peak never fire together and an idle zero period stays idle.
        run_nx  = run_en && (per_nx != '0);
        zero_nx = run_nx && (car_nx == '0);
        peak_nx = run_nx && (car_nx == per_nx);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carrier    <= cnt_t'(RESET_PHASE);
            dir        <= 1'b0;
            zero_evt   <= 1'b0;
            peak_evt   <= 1'b0;
            running    <= 1'b0;
            period_act <= '0;
            mode_act   <= M_UP;
            init_q     <= '0;
        end else begin
            carrier    <= car_nx;
            dir        <= dir_nx;
            zero_evt   <= zero_nx;
            peak_evt   <= peak_nx;
            running    <= run_nx;
            period_act <= per_nx;
            mode_act   <= mode_nx;
            init_q     <= init_carr;
        end
    end

endmodule

// File: doc/pwm_carrier_gen.md
PWM_CARRIER_GEN -- requirements
Module: pwm_carrier_gen

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of period, phase and carrier in bits (legal 4..32).
REQ-002 Parameter RESET_PHASE, default 0, carrier value loaded on reset.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 period  in  CNT_WIDTH  requested carrier peak P; shadowed, see REQ-013.
REQ-006 init_carr  in  CNT_WIDTH  phase offset loaded at start/resync.
REQ-007 count_mode  in  2  00 UP, 01 DOWN, 10 UPDOWN, 11 reserved (treated as UP); shadowed with period.
REQ-008 pwm_onoff  in  1  1 = PWM enabled.
REQ-009 carr_onoff  in  1  1 = this carrier enabled.
REQ-010 sync_in  in  1  single-cycle resync pulse.
REQ-011 carrier  out  CNT_WIDTH  registered carrier count.
REQ-012 dir  out  1 / zero_evt  out  1 / peak_evt  out  1 / running  out  1 -- count direction (1=down), registered one-cycle event strobes, active-run flag.

Function
REQ-013 Active registers period_act and mode_act SHALL load from period/count_mode every cycle while not running, and while running only at the update boundary: UP wrap to 0, DOWN reload to P, UPDOWN turnaround at 0.
REQ-014 run_en = pwm_onoff & carr_onoff & (period_act != 0); running SHALL be the registered run_en.
REQ-015 Priority per cycle: reset > !run_en > (sync_in or init_carr change) > normal count.
REQ-016 !run_en: carrier <= min(init_carr, period), dir <= 0 (UPDOWN/UP) or 1 (DOWN), no events.
REQ-017 Resync (sync_in=1, or init_carr differs from its value registered last cycle) while running: carrier <= min(init_carr, period_act) in one cycle; dir as REQ-016; shadow update NOT taken.
REQ-018 UP: carrier+1 until carrier >= period_act, then 0; period 2^0..: P+1 cycles.
REQ-019 DOWN: carrier-1 until 0, then reload period_act (new shadow value); P+1 cycles.
REQ-020 UPDOWN: count up to P, dir <= 1, count down to 0, dir <= 0; no dwell at ends; sequence 0,1..P,P-1..1,0,1; period 2P cycles.
REQ-021 zero_evt SHALL be 1 exactly in cycles where running and carrier == 0; peak_evt where running and carrier == period_act; both may be 1 when P would be 0 only via invalid state (never while running).
REQ-022 Arithmetic unsigned CNT_WIDTH, no wrap-through: carrier never exceeds period_act while running, never underflows below 0.
REQ-023 Carrier value > new period_act after a boundary update SHALL be impossible; phase clamp applies on load.
REQ-024 First cycle after run_en rises: counting starts from value loaded during idle, one cycle latency to first increment.
REQ-025 Mode change takes effect only at boundary; UPDOWN->UP at turnaround continues upward from 0.

Reset
REQ-026 Async reset: carrier = RESET_PHASE, dir = 0, zero_evt = peak_evt = running = 0, period_act = 0, mode_act = UP, phase register = 0.
REQ-027 Reset deassertion mid-operation SHALL restart from idle path (REQ-016) on the next edge; no partial counts retained.

Verification
REQ-028 UP, P=4, init=0, enable -> carrier 0,1,2,3,4,0,1; zero_evt at 0, peak_evt at 4.
REQ-029 UPDOWN, P=3 -> 0,1,2,3,2,1,0,1; dir 1 on 3..1 transitions; period 6 cycles.
REQ-030 DOWN, P=5 running, period changed to 2 at carrier=3 -> 3,2,1,0,2,1,0,2 (update only at reload).
REQ-031 UP P=10 running, init_carr 0->7 at carrier=2 -> next carrier 7; init_carr=15 -> 10 (clamped).
REQ-032 carr_onoff drop at carrier=6 -> next cycle carrier=init value, running=0, no events; period=0 with enables high -> running stays 0.
REQ-033 Assert reset at carrier=8 asynchronously -> carrier=RESET_PHASE immediately, all strobes 0.
